des_block_ctrl: RTL and testbench

Upstream launcher and result collector for the DES round core. It accepts one 64-bit block per valid/ready handshake and pulses the core's `init`. It then waits for the core's level `finish` flag, captures the core result, and presents it downstream on a second valid/ready handshake. A watchdog flags a core that never finishes.

---
 rtl/des_block_ctrl.sv | 143 ++++++++++++++
 tb/tb_des_block_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_block_ctrl.sv
// des_block_ctrl: launches one block at a time into the DES round core,
// waits for the core's finish level, and hands the result downstream.
// A watchdog bounds the wait and raises a sticky error on a hung core.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A source holds valid (and its data) until that edge, and
// ready never depends combinationally on valid. Here in_ready and out_valid
// are both registered, so no combinational path crosses the block.
module des_block_ctrl #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              core_init,
    output logic [DATA_W-1:0] core_data,
    input  logic              core_finish,
    input  logic [DATA_W-1:0] core_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  blk_cnt,
    output logic [1:0]        state_dbg
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                core_init_q, core_init_d;
    logic [DATA_W-1:0]   core_data_q, core_data_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;

    // Next-state and datapath updates; the registered strobes are derived
    // from the next state so they line up with the state they describe.
    always_comb begin
        state_d     = state_q;
        core_data_d = core_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        blk_cnt_d   = blk_cnt_q;
        wdog_d      = wdog_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    core_data_d = in_data;
                    err_d       = 1'b0;
                    wdog_d      = '0;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // finish may still be high from the previous block; ignore it.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_finish) begin
                    out_data_d  = core_result;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    blk_cnt_d   = blk_cnt_q + 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        core_init_d = (state_d == ST_LAUNCH);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any block in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            core_init_q <= 1'b0;
            core_data_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            blk_cnt_q   <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            core_init_q <= core_init_d;
            core_data_q <= core_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            blk_cnt_q   <= blk_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign core_init = core_init_q;
    assign core_data = core_data_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign blk_cnt   = blk_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_des_block_ctrl.sv
// Bench for des_block_ctrl: a behavioural DES-core stand-in, an expected
// result queue and cycle-count latency expectations derived from the
// core's round count.
`timescale 1ns/1ps
module tb_des_block_ctrl;

    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 32;
    localparam int CNT_W   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              core_init;
    logic [DATA_W-1:0] core_data;
    logic              core_finish = 1'b0;
    logic [DATA_W-1:0] core_result;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              err;
    logic [CNT_W-1:0]  blk_cnt;
    logic [1:0]        state_dbg;

    des_block_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_init(core_init), .core_data(core_data),
        .core_finish(core_finish), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err), .blk_cnt(blk_cnt), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    // ---------------- core stand-in ----------------
    // Sees init at an edge, then raises finish core_rounds edges later and
    // keeps it high until the next init. core_hang suppresses finish.
    int core_rounds = 16;
    bit core_hang = 1'b0;
    int core_cnt = 0;
    bit core_run = 1'b0;
    logic [DATA_W-1:0] core_latched = '0;

    function automatic logic [DATA_W-1:0] ref_cipher(input logic [DATA_W-1:0] x);
        if (x == 64'h0123456789ABCDEF) return 64'h85E813540F0AB405;
        return {x[31:0], x[63:32]} ^ 64'h5A5A0F0F3C3C9696;
    endfunction

    always @(posedge clk) begin
        if (core_init) begin
            core_finish  <= 1'b0;
            core_cnt     <= 0;
            core_run     <= !core_hang;
            core_latched <= core_data;
        end else if (core_run) begin
            if (core_cnt == core_rounds - 1) begin
                core_finish <= 1'b1;
                core_run    <= 1'b0;
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end
    assign core_result = ref_cipher(core_latched);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver: one full block ----------------
    // Accepts data, checks init and latency (core_rounds + 2 edges), then
    // holds backpressure for `hold` cycles with junk on the input side.
    task automatic run_block(input logic [DATA_W-1:0] data, input int hold);
        int lat;
        int inits;
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 60) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wait_in_ready: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = data;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_data  = DATA_W'({$urandom, $urandom});
        exp_q.push_back(ref_cipher(data));
        n_cmp++;
        if (core_init !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
            n_err++;
            $display("FAIL accept: init=%b in_ready=%b busy=%b err=%b expected 1 0 1 0",
                     core_init, in_ready, busy, err);
        end
        n_cmp++;
        if (core_data !== data) begin
            n_err++;
            $display("FAIL core_data: got %h expected %h", core_data, data);
        end
        lat = core_rounds + 2;
        inits = 0;
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (core_init === 1'b1) inits++;
            if (k < lat && out_valid !== 1'b0) begin
                n_cmp++;
                n_err++;
                $display("FAIL early_valid: out_valid=%b at edge %0d expected 0", out_valid, k);
            end
        end
        n_cmp++;
        if (inits != 0) begin
            n_err++;
            $display("FAIL init_pulse: extra init cycles %0d expected 0", inits);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL capture: valid=%b data=%h expected 1 %h", out_valid, out_data, exp_q[0]);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DATA_W'({$urandom, $urandom});
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] || in_ready !== 1'b0 || core_init !== 1'b0) begin
                n_err++;
                $display("FAIL hold: valid=%b data=%h rdy=%b init=%b expected 1 %h 0 0",
                         out_valid, out_data, in_ready, core_init, exp_q[0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_cnt++;
        n_cmp++;
        if (out_valid !== 1'b0 || blk_cnt !== CNT_W'(exp_cnt % (1 << CNT_W)) ||
            in_ready !== 1'b1 || busy !== 1'b0 || core_data !== data) begin
            n_err++;
            $display("FAIL handshake: valid=%b cnt=%0d rdy=%b busy=%b cdata=%h expected 0 %0d 1 0 %h",
                     out_valid, blk_cnt, in_ready, busy, core_data,
                     exp_cnt % (1 << CNT_W), data);
        end
    endtask

    task automatic check_reset_vals(input string name);
        n_cmp++;
        if (in_ready !== 1'b1 || core_init !== 1'b0 || core_data !== '0 || out_valid !== 1'b0 ||
            out_data !== '0 || busy !== 1'b0 || err !== 1'b0 || blk_cnt !== '0) begin
            n_err++;
            $display("FAIL %s: rdy=%b init=%b cdata=%h ov=%b od=%h busy=%b err=%b cnt=%0d expected reset values",
                     name, in_ready, core_init, core_data, out_valid, out_data, busy, err, blk_cnt);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DATA_W'({$urandom, $urandom});
            out_ready = 1'($urandom_range(0, 1));
            tick();
            check_reset_vals("reset_vals");
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b1;
        tick();
        check_reset_vals("after_release");
    endtask

    task automatic test_single_block();
        run_block(64'h0123456789ABCDEF, 0);
    endtask

    task automatic test_backpressure();
        run_block(DATA_W'({$urandom, $urandom}), 10);
    endtask

    task automatic test_stale_finish();
        n_cmp++;
        if (core_finish !== 1'b1) begin
            n_err++;
            $display("FAIL stale_setup: core_finish=%b expected 1", core_finish);
        end
        run_block(DATA_W'({$urandom, $urandom}), 3);
    endtask

    task automatic test_finish_on_timeout_edge();
        core_rounds = TIMEOUT - 1;
        run_block(DATA_W'({$urandom, $urandom}), 1);
        core_rounds = 16;
    endtask

    task automatic test_timeout();
        core_hang = 1'b1;
        in_valid = 1'b1;
        in_data  = DATA_W'({$urandom, $urandom});
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            n_cmp++;
            if (err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL timeout_wait: edge %0d err=%b ov=%b busy=%b expected 0 0 1",
                         k, err, out_valid, busy);
            end
        end
        tick();
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_fire: err=%b busy=%b rdy=%b ov=%b expected 1 0 1 0",
                     err, busy, in_ready, out_valid);
        end
        repeat (3) tick();
        n_cmp++;
        if (err !== 1'b1 || blk_cnt !== CNT_W'(exp_cnt % (1 << CNT_W))) begin
            n_err++;
            $display("FAIL err_sticky: err=%b cnt=%0d expected 1 %0d", err, blk_cnt, exp_cnt % (1 << CNT_W));
        end
        core_hang = 1'b0;
        run_block(DATA_W'({$urandom, $urandom}), 2);
    endtask

    task automatic test_abort();
        in_valid = 1'b1;
        in_data  = DATA_W'({$urandom, $urandom});
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        #2 reset_n = 1'b0;
        #1 check_reset_vals("abort_async");
        tick();
        reset_n = 1'b1;
        exp_cnt = 0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || blk_cnt !== '0) begin
                n_err++;
                $display("FAIL abort_idle: ov=%b busy=%b cnt=%0d expected 0 0 0", out_valid, busy, blk_cnt);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back_wrap();
        for (int b = 0; b < (1 << CNT_W) + 1; b++) begin
            run_block(DATA_W'({$urandom, $urandom}), 0);
        end
        n_cmp++;
        if (blk_cnt !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL wrap: blk_cnt=%0d expected 1", blk_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_stale_finish();
        test_finish_on_timeout_edge();
        test_timeout();
        test_abort();
        test_back_to_back_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
